hs_ram_responder: RTL
=====================

// Module: hs_ram_responder
// PURPOSE
//  RAM-side responder for the hiscore save/restore engine. Owns the single-port
//  work RAM holding the score table and muxes it between the game CPU and the
//  hiscore engine. On a pause request it halts the CPU at a bus-cycle boundary,
//  grants the RAM to the hiscore side, and returns it to the CPU on release.
//  Sits inside target_top, between the CPU RAM decode and the hs_* ports.
// PARAMETERS
//  AW      12      RAM address width (bytes = 2**AW)
//  SETTLE  2       consecutive cpu_idle cycles required before grant (1..15)
//  HS_BASE 12'h000 first hiscore-accessible address (used only with HS_RANGE_CHECK_EN)
//  HS_SIZE 12'h100 hiscore-accessible window length (used only with HS_RANGE_CHECK_EN)
// PORTS
//  clk_sys      in   1   system clock; all logic on its rising edge
//  reset_n      in   1   synchronous, active-low reset
//  pause_req    in   1   hiscore engine requests RAM ownership (level)
//  cpu_idle     in   1   CPU between bus cycles; safe to halt/steal RAM
//  cpu_halt     out  1   stall CPU (feeds CPU wait/pause input)
//  cpu_addr     in   AW  CPU RAM address
//  cpu_din      in   8   CPU write data
//  cpu_we       in   1   CPU write strobe (RAM chip-select qualified)
//  cpu_dout     out  8   RAM read data to CPU (= ram_dout, combinational)
//  hs_address   in   AW  hiscore engine address
//  hs_data_in   in   8   hiscore write data
//  hs_write     in   1   hiscore write strobe
//  hs_data_out  out  8   registered read data to hiscore engine
//  hs_paused    out  1   grant: RAM owned by hiscore side
//  ram_addr     out  AW  RAM address
//  ram_din      out  8   RAM write data
//  ram_we       out  1   RAM write enable
//  ram_dout     in   8   RAM read data, 1-cycle synchronous read
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state RUN, cpu_halt=0, hs_paused=0, hs_data_out=0,
//   settle count=0. Reset mid-PAUSED returns RAM to CPU the next cycle.
//  FSM:
//   RUN     : mux=CPU. pause_req=1 -> HALTING (cpu_halt=1 registered next cycle).
//   HALTING : cpu_halt=1, mux=CPU. Count consecutive cpu_idle cycles; idle=0
//             clears count. count reaches SETTLE -> PAUSED. pause_req=0 -> RUN
//             (abort; cpu_halt drops next cycle, no grant ever issued).
//   PAUSED  : cpu_halt=1, hs_paused=1, mux=HS. pause_req=0 -> RELEASE.
//   RELEASE : hs_paused=0, mux=CPU, cpu_halt=1 for this one cycle -> RUN.
//  Mux: ram_addr/ram_din from selected side; ram_we = selected side strobe only.
//   hs_write outside PAUSED ignored; cpu_we while mux=HS ignored.
//  Read latency (hiscore): hs_address at cycle N -> RAM samples N, ram_dout N+1,
//   hs_data_out valid N+2; updates every cycle in PAUSED, holds otherwise.
//  Grant latency: pause_req rise -> hs_paused high >= SETTLE+2 cycles later.
//  Release: pause_req fall -> hs_paused low next cycle, cpu_halt low 2 cycles later.
//  Addresses use AW bits, no wrap logic (RAM decodes full AW).
// CONFIGURATION
//  HS_RANGE_CHECK_EN defined: in PAUSED, hs_write with address outside
//   [HS_BASE, HS_BASE+HS_SIZE) is suppressed (ram_we=0); reads outside the
//   window return 8'h00 on hs_data_out with the same N+2 latency.
//  Undefined: all AW addresses readable/writable; HS_BASE/HS_SIZE unused.
// STRUCTURE
//  Package hs_resp_pkg: state enum {RUN,HALTING,PAUSED,RELEASE}, default AW=12.
//  Sub-module hs_range_check (combinational window compare + 1-cycle delayed
//   in-range flag), instantiated only under HS_RANGE_CHECK_EN.
// TESTING
//  1 reset_n=0 while PAUSED -> next cycle cpu_halt=0, hs_paused=0, ram_we follows cpu_we.
//  2 pause_req=1, cpu_idle=1 steady, SETTLE=2 -> hs_paused=1 exactly 4 cycles after pause_req rises.
//  3 HALTING, cpu_idle toggles 1,0,1,1 -> grant only after the final 1,1; pause_req=0 mid-count -> RUN, no grant.
//  4 PAUSED: write 8'hA5 @12'h010, read @12'h010 -> hs_data_out=8'hA5 two cycles after address.
//  5 RUN: hs_write=1 @12'h020 data 8'h33 -> ram_we=0; CPU reads original value.
//  6 HS_RANGE_CHECK_EN, window 0x000..0x0FF: write 8'h77 @12'h200 -> RAM unchanged; read @12'h200 -> 8'h00.

Source files
------------

// File: rtl/hs_resp_pkg.sv
// Shared types and defaults for the hiscore RAM responder.
package hs_resp_pkg;

  localparam int unsigned DEF_AW    = 12;
  localparam int unsigned SETTLE_CW = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    PAUSED  = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/hs_ram_responder_if.sv
// Hiscore-engine side of the RAM responder: pause handshake plus RAM access bus.
interface hs_ram_responder_if
  import hs_resp_pkg::*;
#(
  parameter int unsigned AW = DEF_AW
);

  logic          pause_req;
  logic [AW-1:0] hs_address;
  logic [7:0]    hs_data_in;
  logic          hs_write;
  logic [7:0]    hs_data_out;
  logic          hs_paused;

  modport master (
    output pause_req, hs_address, hs_data_in, hs_write,
    input  hs_data_out, hs_paused
  );

  modport slave (
    input  pause_req, hs_address, hs_data_in, hs_write,
    output hs_data_out, hs_paused
  );

endinterface

// File: rtl/hs_range_check.sv
// Window compare for hiscore accesses, plus the same flag delayed to line up with RAM read data.
module hs_range_check
  import hs_resp_pkg::*;
#(
  parameter int unsigned   AW      = DEF_AW,
  parameter logic [AW-1:0] HS_BASE = '0,
  parameter logic [AW-1:0] HS_SIZE = AW'(12'h100)
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] addr,
  output logic          in_range_c,
  output logic          in_range_d
);

  // One extra bit so BASE+SIZE never wraps back into the address space.
  localparam logic [AW:0] LO = {1'b0, HS_BASE};
  localparam logic [AW:0] HI = LO + {1'b0, HS_SIZE};

  assign in_range_c = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) in_range_d <= 1'b0;
    else          in_range_d <= in_range_c;
  end

endmodule

// File: rtl/hs_ram_responder.sv
// Work-RAM owner muxing the score RAM between the game CPU and the hiscore engine.
// Optional address window enforcement for the hiscore side: define HS_RANGE_CHECK_EN.
module hs_ram_responder
  import hs_resp_pkg::*;
#(
  parameter int unsigned   AW      = DEF_AW,
  parameter int unsigned   SETTLE  = 2,
  parameter logic [AW-1:0] HS_BASE = '0,
  parameter logic [AW-1:0] HS_SIZE = AW'(12'h100)
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  cpu_idle,
  output logic                  cpu_halt,
  input  logic [AW-1:0]         cpu_addr,
  input  logic [7:0]            cpu_din,
  input  logic                  cpu_we,
  output logic [7:0]            cpu_dout,
  hs_ram_responder_if.slave     hs,
  output logic [AW-1:0]         ram_addr,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  input  logic [7:0]            ram_dout
);

  localparam int unsigned CW = SETTLE_CW;

  state_e        state;
  logic [CW-1:0] settle_cnt;
  logic          hs_paused_q;
  logic [7:0]    hs_data_q;
  logic          hs_sel;
  logic          wr_ok;
  logic          rd_ok;

`ifdef HS_RANGE_CHECK_EN
  hs_range_check #(
    .AW      (AW),
    .HS_BASE (HS_BASE),
    .HS_SIZE (HS_SIZE)
  ) u_range (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .addr       (hs.hs_address),
    .in_range_c (wr_ok),
    .in_range_d (rd_ok)
  );
`else
  logic unused_window;
  assign unused_window = ^{HS_BASE, HS_SIZE};
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // Ownership FSM; the settle counter is compared registered, so the grant
  // lands one cycle after SETTLE consecutive idle cycles have been seen.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= RUN;
      cpu_halt    <= 1'b0;
      hs_paused_q <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          settle_cnt <= '0;
          if (hs.pause_req) begin
            state    <= HALTING;
            cpu_halt <= 1'b1;
          end
        end
        HALTING: begin
          if (!hs.pause_req) begin
            state      <= RUN;
            cpu_halt   <= 1'b0;
            settle_cnt <= '0;
          end else if (settle_cnt == CW'(SETTLE)) begin
            state       <= PAUSED;
            hs_paused_q <= 1'b1;
            settle_cnt  <= '0;
          end else if (cpu_idle) begin
            settle_cnt <= settle_cnt + CW'(1);
          end else begin
            settle_cnt <= '0;
          end
        end
        PAUSED: begin
          if (!hs.pause_req) begin
            state       <= RELEASE;
            hs_paused_q <= 1'b0;
          end
        end
        RELEASE: begin
          state    <= RUN;
          cpu_halt <= 1'b0;
        end
        default: begin
          state       <= RUN;
          cpu_halt    <= 1'b0;
          hs_paused_q <= 1'b0;
          settle_cnt  <= '0;
        end
      endcase
    end
  end

  // Hiscore read data: capture RAM output every PAUSED cycle, hold otherwise.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)             hs_data_q <= 8'h00;
    else if (state == PAUSED) hs_data_q <= rd_ok ? ram_dout : 8'h00;
  end

  assign hs_sel   = (state == PAUSED);
  assign ram_addr = hs_sel ? hs.hs_address : cpu_addr;
  assign ram_din  = hs_sel ? hs.hs_data_in : cpu_din;
  assign ram_we   = hs_sel ? (hs.hs_write & wr_ok) : cpu_we;

  assign cpu_dout       = ram_dout;
  assign hs.hs_paused   = hs_paused_q;
  assign hs.hs_data_out = hs_data_q;

endmodule
